// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer scanout / GPU write path.
package fb_pkg;
   localparam int H_ACTIVE     = 640;
   localparam int V_ACTIVE     = 480;
   localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
   localparam int ADDR_W       = 19;
   localparam int DATA_W       = 24;

   typedef logic [DATA_W-1:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scan_state_t;
endpackage

// File: rtl/fb_prefetch_fifo.sv
// Synchronous prefetch FIFO with single-cycle flush.
// The head reads as zero while empty so the pixel bus stays quiet.
module fb_prefetch_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 24
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DATA_W-1:0]      wdata,
   output logic [DATA_W-1:0]      rdata,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              full_s;
   logic              do_push_s;
   logic              do_pop_s;

   assign full_s    = (count_r == CNT_FULL);
   assign empty     = (count_r == '0);
   assign do_pop_s  = pop && !empty;
   assign do_push_s = push && (!full_s || do_pop_s);
   assign rdata     = empty ? '0 : mem_r[rd_ptr_r];
   assign count     = count_r;

   // Pointer and occupancy bookkeeping; flush wins over push and pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         if (do_push_s && !do_pop_s)      count_r <= count_r + CNT_W'(1);
         else if (do_pop_s && !do_push_s) count_r <= count_r - CNT_W'(1);
      end
   end

   // Storage array write.
   always_ff @(posedge clk) begin
      if (do_push_s && !flush) mem_r[wr_ptr_r] <= wdata;
   end

   fb_prefetch_fifo_chk u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .pop   (do_pop_s),
      .full  (full_s)
   );
endmodule

// File: rtl/fb_prefetch_fifo_chk.sv
// Checker for the prefetch FIFO: a push into a full FIFO is never expected.
module fb_prefetch_fifo_chk (
   input logic clk,
   input logic rst_n,
   input logic flush,
   input logic push,
   input logic pop,
   input logic full
);
   // The arbiter occupancy rule must keep the FIFO from overflowing.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && full && !pop && !flush));
endmodule

// File: rtl/fb_port_arbiter.sv
// Arbitrates one single-port framebuffer RAM between raster scanout reads
// (priority) and GPU writes, with a bounded wait that forces a stalled write.
module fb_port_arbiter
   import fb_pkg::*;
#(
   parameter int H_ACTIVE    = fb_pkg::H_ACTIVE,
   parameter int V_ACTIVE    = fb_pkg::V_ACTIVE,
   parameter int ADDR_W      = fb_pkg::ADDR_W,
   parameter int DATA_W      = fb_pkg::DATA_W,
   parameter int FIFO_DEPTH  = 4,
   parameter int MAX_WR_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_start,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_underflow,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int OCC_W  = CNT_W + 1;
   localparam int WAIT_W = $clog2(MAX_WR_WAIT + 1);
   localparam logic [ADDR_W-1:0] FRAME_N    = ADDR_W'(H_ACTIVE * V_ACTIVE);
   localparam logic [ADDR_W-1:0] FRAME_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
   localparam logic [OCC_W-1:0]  OCC_DEPTH  = OCC_W'(FIFO_DEPTH);
   localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MAX_WR_WAIT);

   scan_state_t       state_r;
   scan_state_t       state_nx_s;
   logic [ADDR_W-1:0] scan_addr_r;
   logic [ADDR_W-1:0] scan_addr_nx_s;
   logic [ADDR_W-1:0] popped_r;
   logic              inflight_r;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic              underflow_r;
   logic [CNT_W-1:0]  fifo_cnt_s;
   logic              fifo_empty_s;
   logic [OCC_W-1:0]  occ_s;
   logic              rd_ok_s;
   logic              wr_force_s;
   logic              wr_grant_s;
   logic              rd_grant_s;
   logic              pop_s;
   logic              push_s;
   logic              under_set_s;

   // Port arbitration: forced write, then scanout read, then ordinary write.
   always_comb begin
      wr_grant_s = 1'b0;
      rd_grant_s = 1'b0;
      occ_s      = {1'b0, fifo_cnt_s} + {{CNT_W{1'b0}}, inflight_r};
      rd_ok_s    = (state_r == SCAN) && (occ_s < OCC_DEPTH) && !frame_start;
      wr_force_s = wr_valid && (wait_cnt_r == WAIT_MAX);
      if (!rst_n) begin
         wr_grant_s = 1'b0;
      end else if (wr_force_s) begin
         wr_grant_s = 1'b1;
      end else if (rd_ok_s) begin
         rd_grant_s = 1'b1;
      end else begin
         wr_grant_s = wr_valid;
      end
   end

   // Scan sequencing: restart on frame_start, stop after the last pixel read.
   always_comb begin
      state_nx_s     = state_r;
      scan_addr_nx_s = scan_addr_r;
      if (frame_start) begin
         state_nx_s     = SCAN;
         scan_addr_nx_s = '0;
      end else begin
         case (state_r)
            SCAN: begin
               if (rd_grant_s) begin
                  scan_addr_nx_s = scan_addr_r + ADDR_W'(1);
                  state_nx_s     = (scan_addr_r == FRAME_LAST) ? DONE : SCAN;
               end else begin
                  state_nx_s = SCAN;
               end
            end
            default: state_nx_s = state_r;
         endcase
      end
   end

   assign pop_s  = !fifo_empty_s && pix_ready && !frame_start;
   assign push_s = inflight_r && !frame_start;
   // The start-of-frame fill latency (nothing popped yet) is not an underflow.
   assign under_set_s = pix_ready && fifo_empty_s && (popped_r != '0) &&
                        (popped_r < FRAME_N) && (state_r != IDLE);

   // Scan, wait and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         scan_addr_r <= '0;
         inflight_r  <= 1'b0;
         wait_cnt_r  <= '0;
         popped_r    <= '0;
         underflow_r <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         scan_addr_r <= scan_addr_nx_s;
         inflight_r  <= rd_grant_s;
         if (!wr_valid || wr_grant_s)    wait_cnt_r <= '0;
         else if (wait_cnt_r != WAIT_MAX) wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
         if (frame_start) popped_r <= '0;
         else if (pop_s)  popped_r <= popped_r + ADDR_W'(1);
         if (frame_start)      underflow_r <= 1'b0;
         else if (under_set_s) underflow_r <= 1'b1;
      end
   end

   assign wr_ready      = wr_grant_s;
   assign mem_en        = wr_grant_s || rd_grant_s;
   assign mem_we        = wr_grant_s;
   assign mem_addr      = wr_grant_s ? wr_addr : (rd_grant_s ? scan_addr_r : '0);
   assign mem_wdata     = wr_grant_s ? wr_data : '0;
   assign pix_valid     = !fifo_empty_s;
   assign pix_underflow = underflow_r;

   fb_prefetch_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (frame_start),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (mem_rdata),
      .rdata (pix_data),
      .empty (fifo_empty_s),
      .count (fifo_cnt_s)
   );
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter on a reduced 16x16 frame, with a queue-based
// reference model of the scanout pipeline and a behavioural RAM.
module tb_fb_port_arbiter;
   import fb_pkg::*;

   localparam int HA    = 16;
   localparam int VA    = 16;
   localparam int FRAME = HA * VA;
   localparam int DEPTH = 4;
   localparam int MAXW  = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              frame_start;
   logic              pix_valid;
   logic              pix_ready;
   pixel_t            pix_data;
   logic              pix_underflow;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   pixel_t            wr_data;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   pixel_t            mem_wdata;
   pixel_t            mem_rdata;

   pixel_t ram   [FRAME];
   pixel_t m_mem [FRAME];
   pixel_t q[$];
   pixel_t pend[$];
   int     phase, next_rd, popped, wcnt;
   bit     under;

   int     n_chk, n_fail;
   int     n_reads, n_denied, n_pops, gap, max_gap, exp_idx;
   bit     order_on;
   logic   obs_pv;
   pixel_t obs_pd;
   pixel_t saved;

   always #5 clk = ~clk;

   fb_port_arbiter #(
      .H_ACTIVE (HA), .V_ACTIVE (VA), .ADDR_W (ADDR_W), .DATA_W (DATA_W),
      .FIFO_DEPTH (DEPTH), .MAX_WR_WAIT (MAXW)
   ) dut (
      .clk (clk), .rst_n (rst_n), .frame_start (frame_start),
      .pix_valid (pix_valid), .pix_ready (pix_ready), .pix_data (pix_data),
      .pix_underflow (pix_underflow), .wr_valid (wr_valid), .wr_ready (wr_ready),
      .wr_addr (wr_addr), .wr_data (wr_data), .mem_en (mem_en), .mem_we (mem_we),
      .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_rdata (mem_rdata)
   );

   // Single-port RAM with one-cycle read latency.
   always @(posedge clk) begin
      if (mem_en && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[7:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_chk++;
      assert (obs === req) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
      chk({tag, "_pix_data"}, 32'(pix_data), 32'd0);
      chk({tag, "_underflow"}, 32'(pix_underflow), 32'd0);
      chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
      chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
   endtask

   task automatic model_reset();
      q.delete();
      pend.delete();
      phase = 0; next_rd = 0; popped = 0; wcnt = 0; under = 1'b0;
   endtask

   // Who owns the RAM this cycle, from the bench's view of the pipeline.
   function automatic void model_eval(output bit rd, output bit wr);
      bit room, force_wr, rd_ok;
      room     = (q.size() + pend.size()) < DEPTH;
      rd_ok    = (phase == 1) && room && !frame_start;
      force_wr = wr_valid && (wcnt == MAXW);
      wr       = wr_valid && (force_wr || !rd_ok);
      rd       = rd_ok && !force_wr;
   endfunction

   task automatic model_step(input bit rd, input bit wr);
      if (wr) m_mem[int'(wr_addr)] = wr_data;
      if (frame_start) begin
         q.delete();
         pend.delete();
         popped = 0; under = 1'b0; phase = 1; next_rd = 0;
      end else begin
         if (pix_ready && q.size() == 0 && popped != 0 && popped < FRAME && phase != 0)
            under = 1'b1;
         if (pix_ready && q.size() != 0) begin
            void'(q.pop_front());
            popped++;
         end
         while (pend.size() != 0) q.push_back(pend.pop_front());
         if (rd) begin
            pend.push_back(m_mem[next_rd]);
            next_rd++;
            if (next_rd == FRAME) phase = 2;
         end
      end
      if (!wr_valid || wr) wcnt = 0;
      else if (wcnt < MAXW) wcnt++;
   endtask

   // One clock: compare against the model mid-cycle, then advance the model.
   task automatic cycle();
      bit rd, wr;
      @(negedge clk);
      model_eval(rd, wr);
      chk("wr_ready", 32'(wr_ready), 32'(wr));
      chk("mem_en", 32'(mem_en), 32'(rd | wr));
      chk("mem_we", 32'(mem_we), 32'(wr));
      if (rd || wr) chk("mem_addr", 32'(mem_addr), wr ? 32'(wr_addr) : 32'(next_rd));
      if (wr) chk("mem_wdata", 32'(mem_wdata), 32'(wr_data));
      chk("pix_valid", 32'(pix_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("pix_data", 32'(pix_data), 32'(q[0]));
      chk("pix_underflow", 32'(pix_underflow), 32'(under));
      obs_pv = pix_valid;
      obs_pd = pix_data;
      if (mem_en && !mem_we) n_reads++;
      if (wr_valid && !wr_ready) n_denied++;
      if (wr_ready) gap = 0;
      else gap++;
      if (gap > max_gap) max_gap = gap;
      if (pix_valid && pix_ready && !frame_start) begin
         n_pops++;
         if (order_on) begin
            chk("raster_order", 32'(pix_data), 32'(exp_idx));
            exp_idx++;
         end
      end
      @(posedge clk);
      model_step(rd, wr);
      #1;
   endtask

   task automatic rand_write(input int pct);
      wr_valid = ($urandom_range(99) < pct);
      wr_addr  = ADDR_W'($urandom_range(FRAME - 1));
      wr_data  = pixel_t'($urandom);
   endtask

   initial begin
      n_chk = 0; n_fail = 0; n_reads = 0; n_denied = 0; n_pops = 0;
      gap = 0; max_gap = 0; exp_idx = 0; order_on = 1'b0;
      for (int a = 0; a < FRAME; a++) begin
         ram[a]   = pixel_t'(a);
         m_mem[a] = pixel_t'(a);
      end
      model_reset();

      // Reset with a pending write: everything quiet.
      rst_n = 1'b0; frame_start = 1'b0; pix_ready = 1'b0;
      wr_valid = 1'b1; wr_addr = 19'd3; wr_data = 24'habcdef;
      #3;
      chk_all_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1; wr_valid = 1'b0;

      // Full frame, no writes: latency, raster order, clean finish.
      pix_ready = 1'b1; order_on = 1'b1; exp_idx = 0;
      frame_start = 1'b1; cycle(); frame_start = 1'b0;
      cycle(); chk("latency_c1", 32'(obs_pv), 32'd0);
      cycle(); chk("latency_c2", 32'(obs_pv), 32'd0);
      cycle(); chk("latency_c3", 32'(obs_pv), 32'd1);
      for (int i = 0; i < FRAME + 20; i++) cycle();
      order_on = 1'b0;
      chk("frame_pixels", 32'(exp_idx), 32'(FRAME));
      chk("frame_no_underflow", 32'(pix_underflow), 32'd0);
      n_reads = 0;
      repeat (5) cycle();
      chk("done_no_reads", 32'(n_reads), 32'd0);

      // Writer held on during scanout: bounded starvation.
      frame_start = 1'b1; wr_valid = 1'b1; wr_addr = 19'd5; wr_data = 24'hff0000;
      cycle(); frame_start = 1'b0; gap = 0; max_gap = 0;
      repeat (60) cycle();
      chk("wr_gap_bounded", 32'(max_gap <= MAXW), 32'd1);
      wr_valid = 1'b0; cycle();
      chk("mem5_written", 32'(ram[5]), 32'hff0000);

      // Display stalled: FIFO fills with exactly DEPTH reads, then writes flow.
      pix_ready = 1'b0; frame_start = 1'b1; cycle(); frame_start = 1'b0;
      n_reads = 0;
      for (int i = 0; i < 8; i++) begin rand_write(50); cycle(); end
      n_denied = 0;
      for (int i = 0; i < 12; i++) begin rand_write(70); cycle(); end
      chk("fill_reads", 32'(n_reads), 32'(DEPTH));
      chk("fill_wr_no_deny", 32'(n_denied), 32'd0);

      // Forced writes starve the FIFO mid-frame: sticky underflow.
      wr_valid = 1'b0; pix_ready = 1'b1;
      frame_start = 1'b1; cycle(); frame_start = 1'b0;
      for (int i = 0; i < 40; i++) begin rand_write(100); cycle(); end
      wr_valid = 1'b0;
      repeat (10) cycle();
      chk("underflow_sticky", 32'(pix_underflow), 32'd1);
      frame_start = 1'b1; cycle(); frame_start = 1'b0;
      cycle();
      chk("underflow_cleared", 32'(pix_underflow), 32'd0);

      // Restart 100 pixels in, with a read in flight.
      frame_start = 1'b1; cycle(); frame_start = 1'b0;
      n_pops = 0;
      for (int i = 0; i < 400 && n_pops < 100; i++) cycle();
      chk("reached_100_pixels", 32'(n_pops >= 100), 32'd1);
      frame_start = 1'b1; cycle(); frame_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (obs_pv) break;
      end
      chk("restart_valid", 32'(obs_pv), 32'd1);
      chk("restart_first_pixel", 32'(obs_pd), 32'(m_mem[0]));

      // Randomized traffic with occasional restarts.
      for (int i = 0; i < 3000; i++) begin
         pix_ready   = ($urandom_range(3) != 0);
         frame_start = ($urandom_range(399) == 0);
         rand_write(35);
         cycle();
      end
      frame_start = 1'b0;

      // Reset mid-scan with a write pending.
      pix_ready = 1'b1; wr_valid = 1'b0;
      frame_start = 1'b1; cycle(); frame_start = 1'b0;
      repeat (20) cycle();
      wr_valid = 1'b1; wr_addr = 19'd7; wr_data = 24'h123456;
      saved = ram[7];
      rst_n = 1'b0;
      #2;
      chk_all_zero("midreset");
      @(posedge clk); #1;
      chk("midreset_no_write", 32'(ram[7]), 32'(saved));
      rst_n = 1'b1;
      model_reset();
      wr_valid = 1'b0; n_reads = 0;
      repeat (4) cycle();
      chk("idle_no_reads", 32'(n_reads), 32'd0);
      wr_valid = 1'b1; wr_addr = 19'd9; wr_data = 24'h00ff00;
      repeat (3) cycle();
      wr_valid = 1'b0; cycle();
      chk("idle_write_lands", 32'(ram[9]), 32'h00ff00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
